// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: source ids and default widths.
package cdb_arbiter_pkg;
  localparam int NUM_CDB_SRC = 3;
  localparam int RoB_WIDTH   = 4;
  localparam int ADDR_WIDTH  = 32;

  localparam logic [1:0] CDB_SRC_ALU0 = 2'd0;
  localparam logic [1:0] CDB_SRC_ALU1 = 2'd1;
  localparam logic [1:0] CDB_SRC_LSB  = 2'd2;

  // Next source in round-robin order; ids live in 0..2, so 2 wraps to 0.
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == CDB_SRC_LSB) ? CDB_SRC_ALU0 : id + 2'd1;
  endfunction
endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result queue: small circular FIFO with flush; flush beats push and pop.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         Sys_clk,
  input  logic         Sys_rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible through cnt.
  always_ff @(posedge Sys_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three queued producers, round-robin grant, one registered broadcast per cycle.
module cdb_arbiter #(
  parameter int RoB_WIDTH  = cdb_arbiter_pkg::RoB_WIDTH,
  parameter int ADDR_WIDTH = cdb_arbiter_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 2
) (
  input  logic                    Sys_clk,
  input  logic                    Sys_rst_n,
  input  logic                    Sys_rdy,
  input  logic                    RoB_pre_judge,
  input  logic [2:0]              Src_en,
  input  logic [3*RoB_WIDTH-1:0]  Src_RoB_index,
  input  logic [95:0]             Src_value,
  input  logic [3*ADDR_WIDTH-1:0] Src_next_pc,
  output logic [2:0]              Src_full,
  output logic                    CDB_en,
  output logic [1:0]              CDB_src,
  output logic [RoB_WIDTH-1:0]    CDB_RoB_index,
  output logic [31:0]             CDB_value,
  output logic [ADDR_WIDTH-1:0]   CDB_next_pc
);
  import cdb_arbiter_pkg::*;

  localparam int ENT_W = RoB_WIDTH + 32 + ADDR_WIDTH;

  logic [NUM_CDB_SRC-1:0][ENT_W-1:0] src_din, src_head;
  logic [NUM_CDB_SRC-1:0]            src_empty, src_full, src_push, src_pop;
  logic                              flush, live, gnt_vld;
  logic [1:0]                        gnt_id, cand, rr_last;

  assign flush    = Sys_rdy & ~RoB_pre_judge;
  assign live     = Sys_rdy & RoB_pre_judge;
  assign Src_full = src_full;

  for (genvar k = 0; k < NUM_CDB_SRC; k++) begin : g_src
    // The load/store buffer has no meaningful next pc; store zero instead.
    assign src_din[k]  = {Src_RoB_index[k*RoB_WIDTH +: RoB_WIDTH],
                          Src_value[k*32 +: 32],
                          (2'(k) == CDB_SRC_LSB) ? ADDR_WIDTH'(0)
                                                 : Src_next_pc[k*ADDR_WIDTH +: ADDR_WIDTH]};
    assign src_push[k] = Src_en[k] & live;
    assign src_pop[k]  = gnt_vld & (gnt_id == 2'(k)) & live;

    cdb_src_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
      .Sys_clk   (Sys_clk),
      .Sys_rst_n (Sys_rst_n),
      .flush     (flush),
      .push      (src_push[k]),
      .pop       (src_pop[k]),
      .din       (src_din[k]),
      .head      (src_head[k]),
      .full      (src_full[k]),
      .empty     (src_empty[k])
    );
  end

  // Scan rr_last+1, rr_last+2, rr_last; grant the first non-empty queue.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = rr_last;
    cand    = rr_last;
    for (int i = 0; i < NUM_CDB_SRC; i++) begin
      cand = rr_next(cand);
      if (!gnt_vld && !src_empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      rr_last       <= CDB_SRC_LSB;
      CDB_en        <= 1'b0;
      CDB_src       <= '0;
      CDB_RoB_index <= '0;
      CDB_value     <= '0;
      CDB_next_pc   <= '0;
    end else if (!Sys_rdy) begin
      CDB_en <= 1'b0;
    end else if (!RoB_pre_judge) begin
      CDB_en  <= 1'b0;
      rr_last <= CDB_SRC_LSB;
    end else if (gnt_vld) begin
      CDB_en  <= 1'b1;
      CDB_src <= gnt_id;
      rr_last <= gnt_id;
      {CDB_RoB_index, CDB_value, CDB_next_pc} <= src_head[gnt_id];
    end else begin
      CDB_en <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: latency, round-robin order, full queue, flush, stall, async reset.
module tb_cdb_arbiter;
  logic        Sys_clk = 1'b0;
  logic        Sys_rst_n;
  logic        Sys_rdy;
  logic        RoB_pre_judge;
  logic [2:0]  Src_en;
  logic [11:0] Src_RoB_index;
  logic [95:0] Src_value;
  logic [95:0] Src_next_pc;
  logic [2:0]  Src_full;
  logic        CDB_en;
  logic [1:0]  CDB_src;
  logic [3:0]  CDB_RoB_index;
  logic [31:0] CDB_value;
  logic [31:0] CDB_next_pc;

  int n_chk = 0;
  int n_err = 0;

  cdb_arbiter #(.RoB_WIDTH(4), .ADDR_WIDTH(32), .DEPTH(2)) dut (
    .Sys_clk       (Sys_clk),
    .Sys_rst_n     (Sys_rst_n),
    .Sys_rdy       (Sys_rdy),
    .RoB_pre_judge (RoB_pre_judge),
    .Src_en        (Src_en),
    .Src_RoB_index (Src_RoB_index),
    .Src_value     (Src_value),
    .Src_next_pc   (Src_next_pc),
    .Src_full      (Src_full),
    .CDB_en        (CDB_en),
    .CDB_src       (CDB_src),
    .CDB_RoB_index (CDB_RoB_index),
    .CDB_value     (CDB_value),
    .CDB_next_pc   (CDB_next_pc)
  );

  always #5 Sys_clk = ~Sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cdb(input string tag, input logic [1:0] src, input logic [3:0] idx,
                         input logic [31:0] val, input logic [31:0] npc);
    chk({tag, ".en"},  64'(CDB_en), 64'(1));
    chk({tag, ".src"}, 64'(CDB_src), 64'(src));
    chk({tag, ".idx"}, 64'(CDB_RoB_index), 64'(idx));
    chk({tag, ".val"}, 64'(CDB_value), 64'(val));
    chk({tag, ".npc"}, 64'(CDB_next_pc), 64'(npc));
  endtask

  task automatic step();
    @(posedge Sys_clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [3:0] idx, input logic [31:0] val,
                         input logic [31:0] npc);
    Src_RoB_index[k*4 +: 4] = idx;
    Src_value[k*32 +: 32]   = val;
    Src_next_pc[k*32 +: 32] = npc;
  endtask

  task automatic do_reset();
    Sys_rst_n     = 1'b0;
    Sys_rdy       = 1'b1;
    RoB_pre_judge = 1'b1;
    Src_en        = '0;
    step();
    step();
    Sys_rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_src [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [3:0] alu1_idx [$];
    Src_RoB_index = '0;
    Src_value     = '0;
    Src_next_pc   = '0;

    // Reset state
    do_reset();
    chk("rst.en",   64'(CDB_en), 64'(0));
    chk("rst.src",  64'(CDB_src), 64'(0));
    chk("rst.idx",  64'(CDB_RoB_index), 64'(0));
    chk("rst.val",  64'(CDB_value), 64'(0));
    chk("rst.npc",  64'(CDB_next_pc), 64'(0));
    chk("rst.full", 64'(Src_full), 64'(0));

    // Single push ALU0: two-cycle latency, one-cycle pulse
    set_src(0, 4'd5, 32'h1234, 32'h100);
    Src_en = 3'b001;
    step();
    Src_en = '0;
    chk("single.e0", 64'(CDB_en), 64'(0));
    step();
    chk_cdb("single", 2'd0, 4'd5, 32'h1234, 32'h100);
    step();
    chk("single.off", 64'(CDB_en), 64'(0));

    // Simultaneous push after reset: order 0,1,2; LSB next pc forced to 0
    do_reset();
    set_src(0, 4'd1, 32'h11, 32'hA0);
    set_src(1, 4'd2, 32'h22, 32'hB0);
    set_src(2, 4'd3, 32'h33, 32'hC0);
    Src_en = 3'b111;
    step();
    Src_en = '0;
    step();
    chk_cdb("all.s0", 2'd0, 4'd1, 32'h11, 32'hA0);
    step();
    chk_cdb("all.s1", 2'd1, 4'd2, 32'h22, 32'hB0);
    step();
    chk_cdb("all.s2", 2'd2, 4'd3, 32'h33, 32'h0);
    step();
    chk("all.off", 64'(CDB_en), 64'(0));

    // ALU1 full with ALU0/LSB backlogged; third ALU1 push is dropped
    do_reset();
    set_src(0, 4'd8, 32'h80, 32'h800);
    set_src(2, 4'd12, 32'hC0, 32'hC00);
    for (int i = 0; i < 24; i++) begin
      Src_en = (i < 3) ? 3'b111 : (i < 14) ? 3'b101 : 3'b000;
      set_src(1, 4'(4 + i), 32'h40 + 32'(i), 32'h400 + 32'(i));
      step();
      if (i >= 1 && i <= 6) begin
        chk($sformatf("rr.en%0d", i), 64'(CDB_en), 64'(1));
        chk($sformatf("rr.src%0d", i), 64'(CDB_src), 64'(exp_src[i-1]));
      end
      if (i == 1) chk("full.set", 64'(Src_full[1]), 64'(1));
      if (i == 2) chk("full.clr", 64'(Src_full[1]), 64'(0));
      if (CDB_en && CDB_src == 2'd1) alu1_idx.push_back(CDB_RoB_index);
    end
    Src_en = '0;
    chk("full.cnt", 64'(alu1_idx.size()), 64'(2));
    if (alu1_idx.size() >= 2) begin
      chk("full.idx0", 64'(alu1_idx[0]), 64'(4));
      chk("full.idx1", 64'(alu1_idx[1]), 64'(5));
    end

    // Flush mid-backlog: pushes in the flush cycle are discarded too
    do_reset();
    set_src(0, 4'd3, 32'h3, 32'h30);
    set_src(1, 4'd3, 32'h3, 32'h30);
    set_src(2, 4'd3, 32'h3, 32'h30);
    Src_en = 3'b111;
    repeat (4) step();
    RoB_pre_judge = 1'b0;
    step();
    RoB_pre_judge = 1'b1;
    Src_en = '0;
    chk("flush.en",   64'(CDB_en), 64'(0));
    chk("flush.full", 64'(Src_full), 64'(0));
    step();
    chk("flush.stale", 64'(CDB_en), 64'(0));
    set_src(2, 4'd9, 32'h99, 32'h900);
    Src_en = 3'b100;
    step();
    Src_en = '0;
    chk("flush.e0", 64'(CDB_en), 64'(0));
    step();
    chk_cdb("flush.lsb", 2'd2, 4'd9, 32'h99, 32'h0);
    step();
    chk("flush.off", 64'(CDB_en), 64'(0));

    // Sys_rdy stall holds the queued entry
    do_reset();
    set_src(1, 4'd6, 32'h66, 32'h600);
    Src_en = 3'b010;
    step();
    Src_en  = '0;
    Sys_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stall.en%0d", i), 64'(CDB_en), 64'(0));
    end
    Sys_rdy = 1'b1;
    step();
    chk_cdb("stall.out", 2'd1, 4'd6, 32'h66, 32'h600);

    // Async reset mid-stream, then first grant goes to ALU0
    do_reset();
    set_src(0, 4'd1, 32'hA1, 32'h110);
    set_src(1, 4'd2, 32'hA2, 32'h120);
    set_src(2, 4'd3, 32'hA3, 32'h130);
    Src_en = 3'b111;
    step();
    Src_en = '0;
    step();
    chk("arst.pre", 64'(CDB_en), 64'(1));
    #3 Sys_rst_n = 1'b0;
    #1;
    chk("arst.en",  64'(CDB_en), 64'(0));
    chk("arst.idx", 64'(CDB_RoB_index), 64'(0));
    chk("arst.val", 64'(CDB_value), 64'(0));
    chk("arst.npc", 64'(CDB_next_pc), 64'(0));
    #2 Sys_rst_n = 1'b1;
    step();
    chk("arst.empty", 64'(CDB_en), 64'(0));
    set_src(0, 4'd13, 32'hD0, 32'h1D0);
    set_src(1, 4'd14, 32'hE0, 32'h1E0);
    set_src(2, 4'd15, 32'hF0, 32'h1F0);
    Src_en = 3'b111;
    step();
    Src_en = '0;
    step();
    chk_cdb("arst.first", 2'd0, 4'd13, 32'hD0, 32'h1D0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single Common Data Bus between three result producers (two ALU reservation-station ports and the load/store buffer) and broadcasts one result per cycle to the reorder buffer, reservation station and LSB. Each producer pushes into a private 2-entry queue; a round-robin arbiter pops one head per cycle into registered CDB outputs. A mispredict flush (pre_judge low) empties all queues, matching the reorder buffer's flush cycle.

## Interface
- `RoB_WIDTH`, default 4: RoB index width.
- `ADDR_WIDTH`, default 32: next-pc width.
- `DEPTH`, default 2: entries per source queue (power of 2, ≥2).
- `Sys_clk` input, 1 bit: the block's single clock; all state updates on its rising edge.
- `Sys_rst_n` input, 1 bit: reset, asynchronous and active-low.
- `Sys_rdy` input, 1 bit: global enable; when low, state holds.
- `RoB_pre_judge` input, 1 bit: 0 means a mispredict flush this cycle.
- `Src_en` input, 3 bits: per-source push strobe. Bit order is 0 = ALU0, 1 = ALU1, 2 = LSB.
- `Src_RoB_index` input, 3×RoB_WIDTH bits: packed RoB index per source. Source k occupies `[k*RoB_WIDTH +: RoB_WIDTH]`.
- `Src_value` input, 96 bits: packed 32-bit rd value or branch result per source.
- `Src_next_pc` input, 3×ADDR_WIDTH bits: packed next pc per source. The LSB slice is ignored and stored as 0.
- `Src_full` output, 3 bits: per-source queue-full flag. Reset value 0.
- `CDB_en` output, 1 bit: broadcast valid. Reset value 0.
- `CDB_src` output, 2 bits: granted source id. Reset value 0.
- `CDB_RoB_index` output, RoB_WIDTH bits: broadcast RoB index. Reset value 0.
- `CDB_value` output, 32 bits: broadcast value. Reset value 0.
- `CDB_next_pc` output, ADDR_WIDTH bits: broadcast next pc. Reset value 0.

## Operation
- **Queue per source:** circular FIFO with read pointer, write pointer and a count of width log2(DEPTH)+1.
  - `Src_full[k]` = (count_k == DEPTH). It is combinational from registered state only.
  - Push when `Src_en[k]` is high and `Src_full[k]` is low. A push while full is dropped and is a producer protocol error.
  - Push and pop of the same queue in one cycle are both allowed; count stays the same.
- **Arbitration:**
  - `rr_last` (2 bits, reset 2) holds the last granted source.
  - Priority order is rr_last+1, rr_last+2, rr_last, computed modulo 3: 2+1 wraps to 0, and 3 is never a legal value.
  - The first non-empty queue in that order is granted: its head is popped, the CDB output registers are loaded, `CDB_en` <= 1 and `rr_last` <= granted id.
  - If all queues are empty: `CDB_en` <= 0. The data outputs hold their last values and `rr_last` holds.
- **Arbitration sees queue state before this cycle's pushes.** A push into an empty queue is not eligible until the next cycle; there is no bypass.
- **Flush** (`RoB_pre_judge` == 0 while `Sys_rdy` is high):
  - All counts and pointers clear, `CDB_en` <= 0, `rr_last` <= 2.
  - That cycle's pushes are discarded.
  - Flush has priority over push and pop.
- **`Sys_rdy` low:** no push, no pop, no flush; `CDB_en` <= 0; all other state holds.
- **Reset:** all queues empty, `rr_last` = 2, all outputs 0.

## Timing
- Latency is 2 cycles: push sampled at edge E0, granted at edge E1, `CDB_en` high in the cycle after E1.
- Throughput is 1 broadcast per cycle across all sources. `CDB_en` is a single-cycle pulse per result.
- With all 3 sources continuously backlogged, each source is granted exactly once every 3 cycles. Worst-case wait for a queued head is 2 grants.
- `Src_full` deasserts in the cycle after the pop that frees an entry.
- An asynchronous reset mid-broadcast drops `CDB_en` immediately, without waiting for a clock edge.

## Structure
- Shared package holds:
  - `NUM_CDB_SRC` = 3;
  - source ids `CDB_SRC_ALU0` = 0, `CDB_SRC_ALU1` = 1, `CDB_SRC_LSB` = 2;
  - `RoB_WIDTH`, `ADDR_WIDTH`.
- Sub-module `cdb_src_fifo`: one DEPTH-entry queue carrying {RoB index, value, next_pc}, with push, pop, flush and full/empty. It is instantiated 3 times.
- The round-robin grant logic and output registers live in the top.

## Test plan
- **Single push, ALU0:** push ALU0 {idx 5, value 0x1234, next_pc 0x100} at E0 → `CDB_en` = 1 with exactly those fields, `CDB_src` = 0, in the cycle after E1; `CDB_en` = 0 in the following cycle.
- **Simultaneous push, all sources:** push all 3 sources at once (idx 1, 2, 3) after reset → broadcasts come out in order src 0, 1, 2 on 3 consecutive cycles; the LSB broadcast has `CDB_next_pc` = 0.
- **Full queue, ALU1:** push ALU1 on 3 consecutive cycles with ALU0 and the LSB kept backlogged → `Src_full[1]` = 1 after the 2nd push is accepted; the 3rd push is dropped; exactly 2 ALU1 broadcasts are observed.
- **Flush mid-backlog:** fill all queues with 2 entries each, then hold `RoB_pre_judge` = 0 for one cycle → `CDB_en` = 0 next cycle, all `Src_full` = 0, and no stale index is ever broadcast afterwards; the next push to the LSB (idx 9) broadcasts 2 cycles later with `CDB_src` = 2.
- **`Sys_rdy` stall:** with a pending entry queued, hold `Sys_rdy` low for 4 cycles → `CDB_en` stays 0 throughout and the entry broadcasts unchanged once `Sys_rdy` returns.
- **Async reset mid-stream:** assert `Sys_rst_n` low between edges during a stream → outputs go to 0 asynchronously; after release the first grant goes to src 0.
